if_fetch_unit: RTL and testbench

//  Instruction-fetch stage. It sits directly upstream of the IF/ID pipeline register.

---
 rtl/if_fetch_unit_pkg.sv | 28 ++
 rtl/if_fetch_unit_if.sv | 32 +++
 rtl/if_fetch_unit_queue.sv | 76 +++++++
 rtl/if_fetch_unit.sv | 105 ++++++++++
 tb/tb_if_fetch_unit.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/if_fetch_unit_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : if_fetch_unit_pkg                                           |
// | Desc   : Shared types and constants for the instruction-fetch stage. |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
package if_fetch_unit_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0;
  localparam logic [31:0] PC_INC    = 32'd4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  typedef enum logic {
    FETCH  = 1'b0,
    SQUASH = 1'b1
  } fetch_state_t;

  // Force an address onto a word boundary.
  function automatic logic [31:0] alignWord(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage
`default_nettype wire

// File: rtl/if_fetch_unit_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : if_fetch_unit_if                                            |
// | Desc   : Control, instruction-memory and IF/ID-facing signals of the |
// |          fetch stage. master = fetch unit, slave = its environment.  |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
interface if_fetch_unit_if;

  logic        pcWrite;
  logic        redirect;
  logic [31:0] redirectTarget;
  logic        imemReq;
  logic [31:0] imemAddr;
  logic        imemAck;
  logic [31:0] imemRdata;
  logic [31:0] fetchPC;
  logic [31:0] fetchInstruction;
  logic        fetchValid;

  modport master (
    input  pcWrite, redirect, redirectTarget, imemAck, imemRdata,
    output imemReq, imemAddr, fetchPC, fetchInstruction, fetchValid
  );

  modport slave (
    output pcWrite, redirect, redirectTarget, imemAck, imemRdata,
    input  imemReq, imemAddr, fetchPC, fetchInstruction, fetchValid
  );

endinterface
`default_nettype wire

// File: rtl/if_fetch_unit_queue.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : fetch_queue                                                 |
// | Desc   : Small FIFO of {pc, instr} entries between memory returns    |
// |          and IF/ID. Flush empties it; flush wins over push/pop.      |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module fetch_queue
  import if_fetch_unit_pkg::*;
#(
  parameter int QDEPTH = 2,
  localparam int CW = $clog2(QDEPTH) + 1,
  localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t pushData,
  output logic         full,
  output logic         empty,
  output logic [CW-1:0] count,
  output fetch_entry_t head
);

  localparam logic [CW-1:0] C_DEPTH   = CW'(QDEPTH);
  localparam logic [PW-1:0] C_LASTPTR = PW'(QDEPTH - 1);

  fetch_entry_t  r_mem [QDEPTH];
  logic [PW-1:0] r_rdPtr;
  logic [PW-1:0] r_wrPtr;
  logic [CW-1:0] r_count;
  logic          w_doPush;
  logic          w_doPop;

  // Pointer advance that wraps at the last slot (also correct for depth 1).
  function automatic logic [PW-1:0] nextPtr(input logic [PW-1:0] ptr);
    return (ptr == C_LASTPTR) ? '0 : ptr + 1'b1;
  endfunction

  // A push into a full queue is only legal when a pop frees a slot.
  assign w_doPush = push && (!full || pop);
  assign w_doPop  = pop && !empty;

  assign full  = (r_count == C_DEPTH);
  assign empty = (r_count == '0);
  assign count = r_count;
  assign head  = r_mem[r_rdPtr];

  // Storage write; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (w_doPush && !flush) begin
      r_mem[r_wrPtr] <= pushData;
    end
  end

  // Pointer and occupancy tracking.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_rdPtr <= '0;
      r_wrPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_doPush) r_wrPtr <= nextPtr(r_wrPtr);
      if (w_doPop)  r_rdPtr <= nextPtr(r_rdPtr);
      case ({w_doPush, w_doPop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/if_fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : if_fetch_unit                                               |
// | Desc   : Instruction-fetch stage. Owns the fetch PC, issues word     |
// |          fetches over req/ack, queues returns and presents the head  |
// |          (or a NOP bubble) to IF/ID. Redirects squash stale fetches. |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          QDEPTH   = 2
) (
  input  logic            clk,
  input  logic            rst,
  if_fetch_unit_if.master bus
);

  localparam int            CW      = $clog2(QDEPTH) + 1;
  localparam logic [CW-1:0] C_DEPTH = CW'(QDEPTH);

  fetch_state_t  r_state;
  logic [31:0]   r_fetchAddr;
  logic [31:0]   r_staleAddr;

  logic          w_req;
  logic [31:0]   w_addr;
  logic          w_valid;
  logic          w_push;
  logic          w_pop;
  logic          w_full;
  logic          w_empty;
  logic [CW-1:0] w_count;
  fetch_entry_t  w_head;
  fetch_entry_t  w_pushData;

  // In SQUASH the stale request must be completed before a new one can go out.
  assign w_req  = !rst && (((r_state == FETCH) && (w_count < C_DEPTH)) || (r_state == SQUASH));
  assign w_addr = (r_state == SQUASH) ? r_staleAddr : r_fetchAddr;

  assign w_valid = !rst && !w_empty;
  assign w_pop   = bus.pcWrite && w_valid && !bus.redirect;
  assign w_push  = w_req && bus.imemAck && (r_state == FETCH) && !bus.redirect
                   && (!w_full || w_pop);

  assign w_pushData.pc    = r_fetchAddr;
  assign w_pushData.instr = bus.imemRdata;

  fetch_queue #(
    .QDEPTH (QDEPTH)
  ) u_queue (
    .clk      (clk),
    .rst      (rst),
    .push     (w_push),
    .pop      (w_pop),
    .flush    (bus.redirect),
    .pushData (w_pushData),
    .full     (w_full),
    .empty    (w_empty),
    .count    (w_count),
    .head     (w_head)
  );

  assign bus.imemReq          = w_req;
  assign bus.imemAddr         = w_addr;
  assign bus.fetchValid       = w_valid;
  assign bus.fetchInstruction = w_valid ? w_head.instr : NOP_INSTR;
  assign bus.fetchPC          = rst ? RESET_PC : (w_valid ? w_head.pc : r_fetchAddr);

  // Fetch FSM plus fetch/stale address registers; redirect takes priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= FETCH;
      r_fetchAddr <= RESET_PC;
      r_staleAddr <= RESET_PC;
    end else if (bus.redirect) begin
      r_fetchAddr <= alignWord(bus.redirectTarget);
      if (r_state == SQUASH) begin
        r_state <= SQUASH;
      end else if (w_req && !bus.imemAck) begin
        r_staleAddr <= w_addr;
        r_state     <= SQUASH;
      end else begin
        r_state <= FETCH;
      end
    end else begin
      case (r_state)
        FETCH: begin
          if (w_req && bus.imemAck) begin
            r_fetchAddr <= r_fetchAddr + PC_INC;
          end
        end
        SQUASH: begin
          if (bus.imemAck) begin
            r_state <= FETCH;
          end
        end
        default: r_state <= FETCH;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_if_fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : tb_if_fetch_unit                                            |
// | Desc   : Self-checking bench for if_fetch_unit: latency-programmable |
// |          memory model, expected-PC scoreboard and directed checks.   |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module tb_if_fetch_unit;
  import if_fetch_unit_pkg::*;

  logic clk;
  logic rst;
  logic rst2;
  int   checks = 0;
  int   errors = 0;
  int   lat = 0;
  int   lat2 = 0;
  int   waitCnt = 0;
  int   waitCnt2 = 0;
  logic [31:0] expQ[$];

  if_fetch_unit_if bus();
  if_fetch_unit_if bus2();

  if_fetch_unit #(.RESET_PC(32'h0000_0000), .QDEPTH(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  if_fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .QDEPTH(2)) dutWrap (
    .clk (clk),
    .rst (rst2),
    .bus (bus2.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return a ^ 32'h8C01_0013;
  endfunction

  // Memory: acks once the request has waited lat cycles (lat=0 -> same cycle).
  always_comb begin
    bus.imemAck    = bus.imemReq && (waitCnt >= lat);
    bus.imemRdata  = memWord(bus.imemAddr);
    bus2.imemAck   = bus2.imemReq && (waitCnt2 >= lat2);
    bus2.imemRdata = memWord(bus2.imemAddr);
  end

  always @(posedge clk) begin
    if (rst || !bus.imemReq || bus.imemAck) waitCnt <= 0;
    else waitCnt <= waitCnt + 1;
    if (rst2 || !bus2.imemReq || bus2.imemAck) waitCnt2 <= 0;
    else waitCnt2 <= waitCnt2 + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: score any consumed head at negedge, then advance past posedge.
  task automatic tick();
    logic [31:0] e;
    @(negedge clk);
    if (!rst && bus.fetchValid && bus.pcWrite && !bus.redirect) begin
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL sb_extra: observed pc %h expected no instruction", bus.fetchPC);
      end else begin
        e = expQ.pop_front();
        check("sb_pc", bus.fetchPC, e);
        check("sb_instr", bus.fetchInstruction, memWord(e));
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic resetDut(input int latency);
    rst = 1'b1;
    lat = latency;
    tick();
    tick();
    rst = 1'b0;
    #1;
  endtask

  initial begin
    rst = 1'b1;
    rst2 = 1'b1;
    bus.pcWrite = 1'b1;
    bus.redirect = 1'b0;
    bus.redirectTarget = 32'h0;
    bus2.pcWrite = 1'b0;
    bus2.redirect = 1'b0;
    bus2.redirectTarget = 32'h0;
    tick();
    check("rst_req", {31'b0, bus.imemReq}, 32'd0);
    check("rst_valid", {31'b0, bus.fetchValid}, 32'd0);

    // 1: zero-wait memory, continuous consumption
    resetDut(0);
    check("t1_valid0", {31'b0, bus.fetchValid}, 32'd0);
    check("t1_pc0", bus.fetchPC, 32'h0);
    check("t1_instr0", bus.fetchInstruction, NOP_INSTR);
    check("t1_req0", {31'b0, bus.imemReq}, 32'd1);
    for (int i = 0; i < 8; i++) expQ.push_back(32'(i * 4));
    tick();
    check("t1_valid1", {31'b0, bus.fetchValid}, 32'd1);
    for (int i = 0; i < 8; i++) tick();
    check("t1_drained", 32'(expQ.size()), 32'd0);

    // 2: latency, bubbles until the first return
    resetDut(2);
    for (int i = 0; i < 3; i++) begin
      check("t2_bubble_valid", {31'b0, bus.fetchValid}, 32'd0);
      check("t2_bubble_instr", bus.fetchInstruction, NOP_INSTR);
      check("t2_addr_held", bus.imemAddr, 32'h0);
      check("t2_req_held", {31'b0, bus.imemReq}, 32'd1);
      tick();
    end
    check("t2_first_valid", {31'b0, bus.fetchValid}, 32'd1);
    check("t2_first_pc", bus.fetchPC, 32'h0);
    expQ = '{32'h0, 32'h4, 32'h8, 32'hC};
    for (int i = 0; i < 12; i++) tick();
    check("t2_drained", 32'(expQ.size()), 32'd0);

    // 3: stall fills the queue, release drains in order
    bus.pcWrite = 1'b0;
    resetDut(0);
    tick();
    tick();
    check("t3_full_req", {31'b0, bus.imemReq}, 32'd0);
    check("t3_head_pc", bus.fetchPC, 32'h0);
    tick();
    tick();
    tick();
    check("t3_hold_req", {31'b0, bus.imemReq}, 32'd0);
    check("t3_hold_pc", bus.fetchPC, 32'h0);
    check("t3_hold_instr", bus.fetchInstruction, memWord(32'h0));
    bus.pcWrite = 1'b1;
    expQ = '{32'h0, 32'h4, 32'h8};
    for (int i = 0; i < 3; i++) tick();
    bus.pcWrite = 1'b0;
    check("t3_drained", 32'(expQ.size()), 32'd0);

    // 4: redirect with a request outstanding
    bus.pcWrite = 1'b1;
    resetDut(2);
    expQ = '{32'h0};
    for (int i = 0; i < 6; i++) tick();
    check("t4_pre_drained", 32'(expQ.size()), 32'd0);
    check("t4_out_addr", bus.imemAddr, 32'h8);
    check("t4_out_ack", {31'b0, bus.imemAck}, 32'd0);
    bus.redirect = 1'b1;
    bus.redirectTarget = 32'h0000_0103;
    tick();
    bus.redirect = 1'b0;
    #1;
    check("t4_stale_addr", bus.imemAddr, 32'h8);
    check("t4_sq_valid", {31'b0, bus.fetchValid}, 32'd0);
    tick();
    check("t4_stale_ack", {31'b0, bus.imemAck}, 32'd1);
    check("t4_sq_valid2", {31'b0, bus.fetchValid}, 32'd0);
    tick();
    check("t4_target_addr", bus.imemAddr, 32'h100);
    check("t4_target_valid", {31'b0, bus.fetchValid}, 32'd0);
    expQ = '{32'h100, 32'h104};
    for (int i = 0; i < 7; i++) tick();
    check("t4_drained", 32'(expQ.size()), 32'd0);

    // 5: redirect coinciding with push and pop
    resetDut(0);
    tick();
    check("t5_pre_valid", {31'b0, bus.fetchValid}, 32'd1);
    check("t5_pre_ack", {31'b0, bus.imemAck}, 32'd1);
    bus.redirect = 1'b1;
    bus.redirectTarget = 32'h0000_0200;
    tick();
    bus.redirect = 1'b0;
    #1;
    check("t5_flush_valid", {31'b0, bus.fetchValid}, 32'd0);
    check("t5_flush_instr", bus.fetchInstruction, NOP_INSTR);
    check("t5_flush_pc", bus.fetchPC, 32'h200);
    check("t5_target_addr", bus.imemAddr, 32'h200);
    expQ = '{32'h200, 32'h204};
    for (int i = 0; i < 3; i++) tick();
    check("t5_drained", 32'(expQ.size()), 32'd0);

    // 6: reset mid-latency, then fetch across the address wrap
    rst = 1'b1;
    lat2 = 3;
    rst2 = 1'b0;
    #1;
    check("t6_first_req", {31'b0, bus2.imemReq}, 32'd1);
    check("t6_first_addr", bus2.imemAddr, 32'hFFFF_FFF8);
    check("t6_reset_pc", bus2.fetchPC, 32'hFFFF_FFF8);
    tick();
    check("t6_pending_ack", {31'b0, bus2.imemAck}, 32'd0);
    rst2 = 1'b1;
    #1;
    check("t6_rst_req", {31'b0, bus2.imemReq}, 32'd0);
    tick();
    check("t6_rst_req2", {31'b0, bus2.imemReq}, 32'd0);
    check("t6_rst_valid", {31'b0, bus2.fetchValid}, 32'd0);
    lat2 = 0;
    bus2.pcWrite = 1'b1;
    rst2 = 1'b0;
    #1;
    check("t6_addr0", bus2.imemAddr, 32'hFFFF_FFF8);
    check("t6_valid0", {31'b0, bus2.fetchValid}, 32'd0);
    tick();
    check("t6_addr1", bus2.imemAddr, 32'hFFFF_FFFC);
    check("t6_pc1", bus2.fetchPC, 32'hFFFF_FFF8);
    tick();
    check("t6_addr_wrap", bus2.imemAddr, 32'h0000_0000);
    check("t6_pc2", bus2.fetchPC, 32'hFFFF_FFFC);
    tick();
    check("t6_pc_wrap", bus2.fetchPC, 32'h0000_0000);
    check("t6_instr_wrap", bus2.fetchInstruction, memWord(32'h0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
